mem_controller: RTL

Single-port arbiter and serialiser between the two memory clients (instruction cache and load/store unit) and the byte-wide RAM/IO bus. It accepts one 1/2/4-byte request at a time, walks it out as consecutive byte accesses, and assembles read data. It returns each result as a one-cycle completion pulse with sign- or zero-extended data. The LSU has priority over instruction fetch.

---
 rtl/mem_controller_pkg.sv | 45 ++++
 rtl/mem_controller_extend.sv | 35 +++
 rtl/mem_controller.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_controller_pkg.sv
// ---------------------------------------------------------------------------
// mem_controller_pkg
//   Shared definitions for the memory controller slice: bus widths, request
//   direction codes, access width codes, FSM state encodings, the IO region
//   tag and the request-owner type.
// ---------------------------------------------------------------------------
package mem_controller_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  localparam logic TRUE      = 1'b1;
  localparam logic FALSE     = 1'b0;

  // FSM state encodings
  localparam logic [1:0] MC_IDLE  = 2'd0;
  localparam logic [1:0] MC_READ  = 2'd1;
  localparam logic [1:0] MC_WRITE = 2'd2;
  localparam logic [1:0] MC_DONE  = 2'd3;

  // addr[17:16] value that selects the UART / IO window
  localparam logic [1:0] IO_REGION_HI = 2'b11;

  // LSU access width codes; 3 is illegal and handled as a word
  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef enum logic {
    OWN_ICACHE = 1'b0,
    OWN_LSU    = 1'b1
  } owner_e;

  // Number of bytes moved for a width code.
  function automatic logic [2:0] width_to_n(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: width_to_n = 3'd1;
      WIDTH_HALF: width_to_n = 3'd2;
      default:    width_to_n = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_controller_extend.sv
// ---------------------------------------------------------------------------
// mc_extend
//   Combinational load-result extension for the LSU return path.
//   Ports:
//     data      - assembled little-endian bytes (upper bytes may be stale)
//     width     - access width code (byte / half / word, 3 treated as word)
//     is_signed - 1: sign-extend byte/half, 0: zero-extend
//     result    - 32-bit extended value
// ---------------------------------------------------------------------------
module mc_extend
  import mem_controller_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  width,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = data[7:0];
    half_s = data[15:0];
    result = data;
    case (width)
      WIDTH_BYTE: result = is_signed ? {{24{byte_s[7]}}, byte_s}
                                     : {24'd0, data[7:0]};
      WIDTH_HALF: result = is_signed ? {{16{half_s[15]}}, half_s}
                                     : {16'd0, data[15:0]};
      default:    result = data;
    endcase
  end

endmodule

// File: rtl/mem_controller.sv
// ---------------------------------------------------------------------------
// mem_controller
//   Arbitrates the instruction cache and the load/store unit onto a single
//   byte-wide RAM/IO bus. One request (1, 2 or 4 bytes) is accepted at a
//   time, walked out as consecutive byte accesses, and completed with a
//   one-cycle pulse to its owner. The LSU wins over instruction fetch.
//
//   Ports:
//     clk_in, rst_in (async, active-low), rdy_in (global stall, active-high)
//     iCache2memCon_enable/addr       - fetch request (always 4 bytes)
//     memCon2iCache_enable/return     - fetch completion pulse + word
//     lsu2memCon_enable/rw/width/addr/value/ifSigned - LSU request
//     memCon2lsu_enable/return        - LSU completion pulse + load data
//     mem_din/mem_dout/mem_a/mem_wr   - byte bus, RAM read latency 1 cycle
//     io_buffer_full                  - UART full; stalls IO stores
//   All outputs are registered.
// ---------------------------------------------------------------------------
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter bit IO_FULL_WAIT = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        iCache2memCon_enable,
  input  logic [31:0] iCache2memCon_addr,
  output logic        memCon2iCache_enable,
  output logic [31:0] memCon2iCache_return,
  input  logic        lsu2memCon_enable,
  input  logic        lsu2memCon_rw,
  input  logic [1:0]  lsu2memCon_width,
  input  logic [31:0] lsu2memCon_addr,
  input  logic [31:0] lsu2memCon_value,
  input  logic        lsu2memCon_ifSigned,
  output logic        memCon2lsu_enable,
  output logic [31:0] memCon2lsu_return,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  logic [1:0]  state_q;
  owner_e      owner_q;
  logic [31:0] addr_q;
  logic [2:0]  n_q;
  logic [1:0]  width_q;
  logic        sgn_q;
  logic [31:0] value_q;
  logic [31:0] data_q;
  // READ: edges since accept (1 = first address cycle).
  // WRITE: index of the byte currently presented on the bus.
  logic [2:0]  cnt_q;

  // A store byte is held back while its address is in the IO window and the
  // UART cannot take it.
  function automatic logic io_stall(input logic [1:0] region, input logic full);
    io_stall = IO_FULL_WAIT && (region == IO_REGION_HI) && full;
  endfunction

  // Arbitration: LSU first, fetch otherwise.
  logic        acc_valid;
  logic        acc_lsu;
  logic        acc_rw;
  logic [1:0]  acc_width;
  logic [31:0] acc_addr;
  logic [31:0] acc_value;
  logic        acc_sgn;

  always_comb begin
    acc_valid = lsu2memCon_enable || iCache2memCon_enable;
    acc_lsu   = lsu2memCon_enable;
    acc_rw    = acc_lsu ? lsu2memCon_rw       : MEM_READ;
    acc_width = acc_lsu ? lsu2memCon_width    : WIDTH_WORD;
    acc_addr  = acc_lsu ? lsu2memCon_addr     : iCache2memCon_addr;
    acc_value = acc_lsu ? lsu2memCon_value    : 32'd0;
    acc_sgn   = acc_lsu ? lsu2memCon_ifSigned : FALSE;
  end

  // Read capture: the byte addressed two edges ago is on mem_din now, so the
  // byte slot is cnt_q-2. The merged word feeds the completion path so the
  // last byte is included in the pulse data without an extra cycle.
  logic [1:0]  cap_idx;
  logic [31:0] cap_data;
  logic [31:0] ext_data;

  always_comb begin
    cap_idx  = cnt_q[1:0] - 2'd2;
    cap_data = data_q;
    if (cnt_q >= 3'd2) begin
      cap_data[{cap_idx, 3'b000} +: 8] = mem_din;
    end
  end

  mc_extend u_extend (
    .data      (cap_data),
    .width     (width_q),
    .is_signed (sgn_q),
    .result    (ext_data)
  );

  // Write stepping: a byte advances only in a cycle where it was actually
  // written; a stalled byte is presented again.
  logic [2:0]  wr_next_idx;
  logic [31:0] wr_addr;
  logic [7:0]  wr_byte;

  always_comb begin
    wr_next_idx = mem_wr ? (cnt_q + 3'd1) : cnt_q;
    wr_addr     = addr_q + {29'd0, wr_next_idx};
    wr_byte     = value_q[{wr_next_idx[1:0], 3'b000} +: 8];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q              <= MC_IDLE;
      owner_q              <= OWN_ICACHE;
      addr_q               <= '0;
      n_q                  <= '0;
      width_q              <= '0;
      sgn_q                <= 1'b0;
      value_q              <= '0;
      data_q               <= '0;
      cnt_q                <= '0;
      mem_a                <= '0;
      mem_dout             <= '0;
      mem_wr               <= 1'b0;
      memCon2lsu_enable    <= 1'b0;
      memCon2lsu_return    <= '0;
      memCon2iCache_enable <= 1'b0;
      memCon2iCache_return <= '0;
    end else if (rdy_in) begin
      case (state_q)
        MC_IDLE: begin
          if (acc_valid) begin
            owner_q <= acc_lsu ? OWN_LSU : OWN_ICACHE;
            addr_q  <= acc_addr;
            n_q     <= width_to_n(acc_width);
            width_q <= acc_width;
            sgn_q   <= acc_sgn;
            value_q <= acc_value;
            data_q  <= '0;
            mem_a   <= acc_addr;
            if (acc_rw == MEM_WRITE) begin
              state_q  <= MC_WRITE;
              cnt_q    <= 3'd0;
              mem_dout <= acc_value[7:0];
              mem_wr   <= !io_stall(acc_addr[17:16], io_buffer_full);
            end else begin
              state_q <= MC_READ;
              cnt_q   <= 3'd1;
            end
          end
        end

        MC_READ: begin
          mem_a  <= (cnt_q < n_q) ? (addr_q + {29'd0, cnt_q}) : 32'd0;
          data_q <= cap_data;
          cnt_q  <= cnt_q + 3'd1;
          if (cnt_q == n_q + 3'd1) begin
            state_q <= MC_DONE;
            if (owner_q == OWN_LSU) begin
              memCon2lsu_enable <= 1'b1;
              memCon2lsu_return <= ext_data;
            end else begin
              memCon2iCache_enable <= 1'b1;
              memCon2iCache_return <= cap_data;
            end
          end
        end

        MC_WRITE: begin
          if (wr_next_idx == n_q) begin
            state_q           <= MC_DONE;
            mem_wr            <= 1'b0;
            mem_a             <= '0;
            mem_dout          <= '0;
            memCon2lsu_enable <= 1'b1;
            memCon2lsu_return <= '0;
          end else begin
            cnt_q    <= wr_next_idx;
            mem_a    <= wr_addr;
            mem_dout <= wr_byte;
            mem_wr   <= !io_stall(wr_addr[17:16], io_buffer_full);
          end
        end

        MC_DONE: begin
          state_q              <= MC_IDLE;
          memCon2lsu_enable    <= 1'b0;
          memCon2lsu_return    <= '0;
          memCon2iCache_enable <= 1'b0;
          memCon2iCache_return <= '0;
        end

        default: state_q <= MC_IDLE;
      endcase
    end
  end

endmodule
